// File: rtl/reset_seq_pkg.sv
// Shared types and elaboration helpers for the board reset sequencer.
package reset_seq_pkg;

   typedef enum logic [2:0] {
      ST_ASSERT,
      ST_WAIT_READY,
      ST_GAP,
      ST_DONE,
      ST_ERROR
   } state_t;

   // Width of a channel index; never narrower than one bit.
   function automatic int unsigned chan_w(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   // True when a CNT_W-bit counter can represent every configured cycle count.
   function automatic bit cnt_w_fits(input int unsigned cnt_w,
                                     input int unsigned hold,
                                     input int unsigned gap,
                                     input int unsigned timeout);
      longint unsigned lim;
      if (cnt_w >= 32) return 1'b1;
      lim = 64'(1) << cnt_w;
      return (64'(hold) < lim) && (64'(gap) < lim) && (64'(timeout) < lim);
   endfunction

endpackage

// File: rtl/sync_bits.sv
// Parametrised-width two-flop synchroniser, synchronously cleared.
module sync_bits #(
   parameter int unsigned W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] meta;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/reset_sequencer.sv
// Releases N reset domains in index order, waiting for each to report ready.
// Optional DONE-state watchdog restart: define RESET_SEQ_WATCHDOG_EN.
module reset_sequencer
   import reset_seq_pkg::*;
#(
   parameter int unsigned NUM_CHANNELS   = 4,
   parameter int unsigned HOLD_CYCLES    = 1024,
   parameter int unsigned GAP_CYCLES     = 16,
   parameter int unsigned TIMEOUT_CYCLES = 65535,
   parameter int unsigned CNT_W          = 17,
   localparam int unsigned CW            = chan_w(NUM_CHANNELS)
) (
   input  logic                    clk_50mhz,
   input  logic                    rst_50mhz,
   input  logic                    soft_reset_in,
   input  logic [NUM_CHANNELS-1:0] ready_in,
   output logic [NUM_CHANNELS-1:0] rst_out,
   output logic                    busy,
   output logic                    done,
   output logic                    timeout_err,
   output logic [CW-1:0]           fail_chan
`ifdef RESET_SEQ_WATCHDOG_EN
   ,
   output logic [7:0]              restart_count
`endif
);

   localparam logic [NUM_CHANNELS-1:0] ONE      = NUM_CHANNELS'(1);
   localparam logic [NUM_CHANNELS-1:0] ALL      = '1;
   localparam logic [CNT_W-1:0]        HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0]        GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
   localparam logic [CNT_W-1:0]        TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0]           LAST_K    = CW'(NUM_CHANNELS - 1);

   if (!cnt_w_fits(CNT_W, HOLD_CYCLES, GAP_CYCLES, TIMEOUT_CYCLES) ||
       NUM_CHANNELS < 1 || NUM_CHANNELS > 16 ||
       HOLD_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
      $error("reset_sequencer: illegal parameter combination");
   end

   state_t                  state, state_nxt;
   logic [CNT_W-1:0]        cnt, cnt_nxt;
   logic [CW-1:0]           k, k_nxt, k_inc;
   logic [NUM_CHANNELS-1:0] rdy_s, rst_nxt;
   logic                    rdy_k;
   logic                    restart;

`ifdef RESET_SEQ_WATCHDOG_EN
   logic [1:0] wd_cnt, wd_nxt;
   logic       wd_fire;
`endif

   sync_bits #(.W(NUM_CHANNELS)) u_sync (
      .clk (clk_50mhz),
      .rst (rst_50mhz),
      .d   (ready_in),
      .q   (rdy_s)
   );

   assign k_inc = k + CW'(1);
   assign rdy_k = |(rdy_s & (ONE << k));

   // Next-state, counter and reset-vector logic.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      k_nxt     = k;
      rst_nxt   = rst_out;
`ifdef RESET_SEQ_WATCHDOG_EN
      wd_nxt    = 2'd0;
      wd_fire   = 1'b0;
`endif

      case (state)
         ST_ASSERT: begin
            if (cnt == HOLD_LAST) begin
               rst_nxt   = rst_out & ~ONE;
               cnt_nxt   = '0;
               state_nxt = ST_WAIT_READY;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         ST_WAIT_READY: begin
            if (rdy_k) begin
               cnt_nxt = '0;
               if (k == LAST_K) begin
                  state_nxt = ST_DONE;
               end else if (GAP_CYCLES == 0) begin
                  rst_nxt = rst_out & ~(ONE << k_inc);
                  k_nxt   = k_inc;
               end else begin
                  state_nxt = ST_GAP;
               end
            end else if (cnt == TO_LAST) begin
               // Park the failed domain back in reset alongside the later ones.
               rst_nxt   = rst_out | (ALL << k);
               state_nxt = ST_ERROR;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         ST_GAP: begin
            if (cnt == GAP_LAST) begin
               rst_nxt   = rst_out & ~(ONE << k_inc);
               k_nxt     = k_inc;
               cnt_nxt   = '0;
               state_nxt = ST_WAIT_READY;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         ST_DONE: begin
`ifdef RESET_SEQ_WATCHDOG_EN
            if (!(&rdy_s)) begin
               if (wd_cnt == 2'd3) wd_fire = 1'b1;
               else                wd_nxt  = wd_cnt + 2'd1;
            end
`else
            state_nxt = ST_DONE;
`endif
         end
         ST_ERROR: state_nxt = ST_ERROR;
         default:  state_nxt = ST_ASSERT;
      endcase

`ifdef RESET_SEQ_WATCHDOG_EN
      restart = soft_reset_in | wd_fire;
`else
      restart = soft_reset_in;
`endif
      if (restart) begin
         state_nxt = ST_ASSERT;
         cnt_nxt   = '0;
         k_nxt     = '0;
         rst_nxt   = '1;
      end
   end

   // State register with registered status outputs.
   always_ff @(posedge clk_50mhz) begin
      if (rst_50mhz) begin
         state       <= ST_ASSERT;
         cnt         <= '0;
         k           <= '0;
         rst_out     <= '1;
         busy        <= 1'b1;
         done        <= 1'b0;
         timeout_err <= 1'b0;
         fail_chan   <= '0;
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         k           <= k_nxt;
         rst_out     <= rst_nxt;
         busy        <= state_nxt inside {ST_ASSERT, ST_WAIT_READY, ST_GAP};
         done        <= (state_nxt == ST_DONE);
         timeout_err <= (state_nxt == ST_ERROR);
         fail_chan   <= (state_nxt == ST_ERROR) ? k_nxt : '0;
      end
   end

`ifdef RESET_SEQ_WATCHDOG_EN
   // Watchdog run-length counter and saturating restart tally.
   always_ff @(posedge clk_50mhz) begin
      if (rst_50mhz) begin
         wd_cnt        <= 2'd0;
         restart_count <= 8'd0;
      end else begin
         wd_cnt <= wd_nxt;
         if (wd_fire && restart_count != 8'hFF)
            restart_count <= restart_count + 8'd1;
      end
   end
`endif

endmodule
